// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
// Shared types and constants for the register-dump trace initiator.
//   state_t     : frame FSM states (HILO only exists when REG_DUMP_HILO_EN is defined)
//   HDR_WORDS   : PC + instruction header words at the start of each frame
//   HILO_WORDS  : trailing HI/LO words (0 unless REG_DUMP_HILO_EN is defined)
//   frame_words : total frame length for a given register count
// Optional feature macro: REG_DUMP_HILO_EN
package reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR_PC    = 3'd1,
        ST_HDR_INSTR = 3'd2,
        ST_SCAN      = 3'd3,
`ifdef REG_DUMP_HILO_EN
        ST_HILO      = 3'd4,
`endif
        ST_FIN       = 3'd5
    } state_t;

    localparam int HDR_WORDS = 2;

`ifdef REG_DUMP_HILO_EN
    localparam int HILO_WORDS = 2;
`else
    localparam int HILO_WORDS = 0;
`endif

    function automatic int frame_words(input int nregs);
        return HDR_WORDS + nregs + HILO_WORDS;
    endfunction

endpackage

// File: rtl/reg_dump_scanner_trigger.sv
// reg_dump_trigger
// Combines the start request with the PC-match trigger and keeps the
// "armed" flag that stops a parked CPU from retriggering on the same PC.
//   clk, rst   : clock, asynchronous active-high reset
//   idle       : frame FSM is idle (requests outside idle are dropped)
//   start      : one-cycle dump request
//   trig_en    : enables the PC-match trigger
//   trig_pc    : PC value that triggers a dump
//   pc_i       : current CPU PC
//   trig       : combinational one-cycle pulse, sampled by the FSM on the same edge
module reg_dump_trigger #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          idle,
    input  logic          start,
    input  logic          trig_en,
    input  logic [DW-1:0] trig_pc,
    input  logic [DW-1:0] pc_i,
    output logic          trig
);

    logic armed_r;
    logic pc_match_s;
    logic pc_fire_s;

    assign pc_match_s = (pc_i == trig_pc);
    assign pc_fire_s  = idle && trig_en && armed_r && pc_match_s;
    // trig must be combinational so the frame starts on the edge that samples the request
    assign trig       = idle && (start || pc_fire_s);

    // Armed flag: dropped when a PC match fires, restored only once the PC has left trig_pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r <= 1'b1;
        end else if (pc_fire_s) begin
            armed_r <= 1'b0;
        end else if (idle && !pc_match_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

endmodule

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner
// On a start pulse or PC-match trigger, freezes the CPU and streams a frame
// of PC, instruction and every register (optionally HI/LO) over valid/ready.
//   clk, rst            : clock, asynchronous active-high reset
//   start, trig_en      : dump request / PC-trigger enable
//   trig_pc, pc_i       : trigger PC and current CPU PC
//   instr_i             : current CPU instruction
//   reg_sel, reg_data   : CPU register-file debug port (reg_data is combinational)
//   hi_i, lo_i          : HI/LO registers (appended only with REG_DUMP_HILO_EN)
//   cpu_hold            : stalls the CPU while the frame is being read
//   out_valid/ready/data/last : frame word stream
//   busy, done          : frame in progress / one-cycle completion pulse
// Optional feature macro: REG_DUMP_HILO_EN
module reg_dump_scanner
    import reg_dump_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          trig_en,
    input  logic [DW-1:0] trig_pc,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] instr_i,
    output logic [4:0]    reg_sel,
    input  logic [DW-1:0] reg_data,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    output logic          cpu_hold,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [5:0] LAST_IDX = 6'(NREGS - 1);

    state_t        state_r;
    logic [5:0]    idx_r;
    logic [DW-1:0] pc_snap_r;
    logic [DW-1:0] instr_snap_r;
    logic          trig_s;
    logic          idle_s;
    logic          hs_s;

    assign idle_s  = (state_r == ST_IDLE);
    assign hs_s    = out_valid && out_ready;
    // idx is also reused as the hi/lo selector in the HILO state
    assign reg_sel = idx_r[4:0];

`ifndef REG_DUMP_HILO_EN
    logic unused_hilo_s;
    assign unused_hilo_s = ^{hi_i, lo_i};
`endif

    reg_dump_trigger #(.DW(DW)) u_trigger (
        .clk     (clk),
        .rst     (rst),
        .idle    (idle_s),
        .start   (start),
        .trig_en (trig_en),
        .trig_pc (trig_pc),
        .pc_i    (pc_i),
        .trig    (trig_s)
    );

    // Frame FSM: state, register index, header snapshots and registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 6'd0;
            pc_snap_r    <= '0;
            instr_snap_r <= '0;
            cpu_hold     <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (trig_s) begin
                        state_r      <= ST_HDR_PC;
                        idx_r        <= 6'd0;
                        pc_snap_r    <= pc_i;
                        instr_snap_r <= instr_i;
                        cpu_hold     <= 1'b1;
                        out_valid    <= 1'b1;
                        out_last     <= 1'b0;
                        busy         <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        cpu_hold  <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_HDR_PC: begin
                    if (hs_s) begin
                        state_r <= ST_HDR_INSTR;
                    end else begin
                        state_r <= ST_HDR_PC;
                    end
                end
                ST_HDR_INSTR: begin
                    if (hs_s) begin
                        state_r <= ST_SCAN;
                    end else begin
                        state_r <= ST_HDR_INSTR;
                    end
                end
                ST_SCAN: begin
                    if (hs_s) begin
                        if (idx_r == LAST_IDX) begin
`ifdef REG_DUMP_HILO_EN
                            state_r <= ST_HILO;
                            idx_r   <= 6'd0;
`else
                            state_r   <= ST_FIN;
                            idx_r     <= 6'd0;
                            cpu_hold  <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            idx_r <= idx_r + 6'd1;
`ifndef REG_DUMP_HILO_EN
                            // the next register word is the final word of the frame
                            out_last <= (idx_r == LAST_IDX - 6'd1);
`endif
                        end
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
`ifdef REG_DUMP_HILO_EN
                ST_HILO: begin
                    if (hs_s) begin
                        if (idx_r[0]) begin
                            state_r   <= ST_FIN;
                            idx_r     <= 6'd0;
                            cpu_hold  <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx_r    <= 6'd1;
                            out_last <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_HILO;
                    end
                end
`endif
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= 6'd0;
                    cpu_hold  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Stream word mux: register words pass straight through from the held CPU
    always_comb begin
        out_data = '0;
        case (state_r)
            ST_HDR_PC:    out_data = pc_snap_r;
            ST_HDR_INSTR: out_data = instr_snap_r;
            ST_SCAN:      out_data = reg_data;
`ifdef REG_DUMP_HILO_EN
            ST_HILO: begin
                if (idx_r[0]) begin
                    out_data = lo_i;
                end else begin
                    out_data = hi_i;
                end
            end
`endif
            default:      out_data = '0;
        endcase
    end

endmodule
